memory_fifo_unit: RTL and testbench

//  Parametrised successor to the single-register memory unit: a DEPTH-entry,

---
 rtl/memory_fifo_unit.sv | 95 +++++++++
 tb/tb_memory_fifo_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/memory_fifo_unit.sv
// DEPTH x WIDTH synchronous FIFO with level/full/empty and sticky ovf/udf; 1-cycle rden->dout.
// No backpressure: a write to a full FIFO is dropped (or evicts the oldest entry when OVERWRITE=1).
module memory_fifo_unit #(
    parameter int WIDTH     = 35,
    parameter int DEPTH     = 8,
    parameter bit OVERWRITE = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             wren,
    input  logic [WIDTH-1:0] din,
    input  logic             rden,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic             ovf_evt;
    logic             udf_evt;
    logic             evict;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // A full FIFO can still take a write when a read frees a slot the same cycle.
    always_comb begin
        rd_ok   = rden && !empty;
        wr_ok   = wren && (!full || rden);
        ovf_evt = wren && full && !rden;
        udf_evt = rden && empty;
        evict   = OVERWRITE && ovf_evt;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            dvalid <= rd_ok;
            if (rd_ok) begin
                dout <= mem[rd_ptr];
            end
            if (wr_ok || evict) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // Eviction advances the read side too, so level stays pinned at DEPTH.
            if (rd_ok || evict) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                level <= level + LVL_ONE;
            end else if (rd_ok && !wr_ok) begin
                level <= level - LVL_ONE;
            end
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (udf_evt) begin
                udf <= 1'b1;
            end else if (clr_flags) begin
                udf <= 1'b0;
            end
        end
    end

    // Storage is not reset; reset only blocks the write that cycle.
    always_ff @(posedge clk) begin
        if (!arst && (wr_ok || evict)) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_memory_fifo_unit.sv
// Scoreboard bench for memory_fifo_unit: one drop-mode and one overwrite-mode instance,
// driven one at a time against a queue reference model.
module tb_memory_fifo_unit;

    localparam int W = 35;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         arst0 = 1'b1, wren0 = 1'b0, rden0 = 1'b0, clr0 = 1'b0;
    logic         arst1 = 1'b1, wren1 = 1'b0, rden1 = 1'b0, clr1 = 1'b0;
    logic [W-1:0] din0 = '0, din1 = '0;
    logic [W-1:0] dout0, dout1;
    logic         dvalid0, dvalid1, full0, full1, empty0, empty1;
    logic         ovf0, ovf1, udf0, udf1;
    logic [3:0]   level0, level1;

    memory_fifo_unit #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) dut_drop (
        .clk(clk), .arst(arst0), .wren(wren0), .din(din0), .rden(rden0),
        .clr_flags(clr0), .dout(dout0), .dvalid(dvalid0), .full(full0),
        .empty(empty0), .level(level0), .ovf(ovf0), .udf(udf0)
    );

    memory_fifo_unit #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) dut_ovw (
        .clk(clk), .arst(arst1), .wren(wren1), .din(din1), .rden(rden1),
        .clr_flags(clr1), .dout(dout1), .dvalid(dvalid1), .full(full1),
        .empty(empty1), .level(level1), .ovf(ovf1), .udf(udf1)
    );

    bit           sel = 1'b0;
    logic [W-1:0] o_dout;
    logic         o_dvalid, o_full, o_empty, o_ovf, o_udf;
    logic [3:0]   o_level;

    assign o_dout   = sel ? dout1   : dout0;
    assign o_dvalid = sel ? dvalid1 : dvalid0;
    assign o_full   = sel ? full1   : full0;
    assign o_empty  = sel ? empty1  : empty0;
    assign o_level  = sel ? level1  : level0;
    assign o_ovf    = sel ? ovf1    : ovf0;
    assign o_udf    = sel ? udf1    : udf0;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_dout = '0;
    bit           m_ovf = 1'b0, m_udf = 1'b0, exp_dv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c, input bit rst);
        bit full_m, empty_m, rd_ok, wr_ok, drop_evt;
        logic [W-1:0] v;
        full_m   = (mq.size() == D);
        empty_m  = (mq.size() == 0);
        rd_ok    = r && !empty_m;
        wr_ok    = w && (!full_m || r);
        drop_evt = w && full_m && !r;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            exp_dv = 1'b0;
        end else begin
            exp_dv = rd_ok;
            if (rd_ok) begin
                v = mq.pop_front();
                exp_q.push_back(v);
                m_dout = v;
            end
            if (drop_evt && sel) void'(mq.pop_front());
            if (wr_ok || (drop_evt && sel)) mq.push_back(d);
            if (drop_evt) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
            if (r && empty_m) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        end

        arst0 = !sel && rst; wren0 = !sel && w; rden0 = !sel && r; clr0 = !sel && c; din0 = d;
        arst1 =  sel && rst; wren1 =  sel && w; rden1 =  sel && r; clr1 =  sel && c; din1 = d;
        @(posedge clk);
        #1;
        arst0 = 1'b0; wren0 = 1'b0; rden0 = 1'b0; clr0 = 1'b0;
        arst1 = 1'b0; wren1 = 1'b0; rden1 = 1'b0; clr1 = 1'b0;

        chk("dvalid", 64'(o_dvalid), 64'(exp_dv));
        if (o_dvalid && exp_q.size() != 0) chk("dout", 64'(o_dout), 64'(exp_q.pop_front()));
        else                               chk("dout_hold", 64'(o_dout), 64'(m_dout));
        if (exp_q.size() != 0) begin
            chk("sb_drain", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        chk("level", 64'(o_level), 64'(mq.size()));
        chk("full",  64'(o_full),  64'(mq.size() == D));
        chk("empty", 64'(o_empty), 64'(mq.size() == 0));
        chk("ovf",   64'(o_ovf),   64'(m_ovf));
        chk("udf",   64'(o_udf),   64'(m_udf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b1; step(0, '0, 0, 0, 1);
        sel = 1'b0; step(0, '0, 0, 0, 1);

        // fill, drop on full
        for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 0, 0);
        chk("fill_level", 64'(o_level), 64'd8);
        step(1, W'(9), 0, 0, 0);
        chk("drop_ovf", 64'(o_ovf), 64'd1);

        // drain, then underflow
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("udf_dout_kept", 64'(o_dout), 64'h8);
        chk("udf_set", 64'(o_udf), 64'd1);

        // simultaneous read+write while full
        step(0, '0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 0, 0);
        step(1, W'(9), 1, 0, 0);
        chk("full_rw_dout", 64'(o_dout), 64'h1);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0);
        chk("full_rw_last", 64'(o_dout), 64'h9);

        // reset mid-operation with wren/rden asserted
        step(0, '0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) step(1, W'(i + 16), 0, 0, 0);
        step(1, W'(16'h77), 1, 0, 1);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_dout", 64'(o_dout), 64'd0);

        // pointer wrap and flag clear priority
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int k = 0; k < 5; k++) step(1, W'(rnd * 16 + k + 32), 0, 0, 0);
            for (int k = 0; k < 5; k++) step(0, '0, 1, 0, 0);
        end
        step(0, '0, 1, 1, 0);
        chk("clr_vs_udf", 64'(o_udf), 64'd1);
        step(0, '0, 0, 1, 0);
        chk("clr_udf", 64'(o_udf), 64'd0);

        // overwrite-oldest instance
        sel = 1'b1;
        step(0, '0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, W'(i), 0, 0, 0);
        chk("ovw_level", 64'(o_level), 64'd8);
        chk("ovw_ovf", 64'(o_ovf), 64'd1);
        step(0, '0, 1, 0, 0);
        chk("ovw_first", 64'(o_dout), 64'h3);
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0, 0);
        chk("ovw_last", 64'(o_dout), 64'hA);

        // random traffic on both variants
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            step(0, '0, 0, 0, 1);
            for (int n = 0; n < 300; n++) begin
                logic [W-1:0] rd_data;
                rd_data = {3'($urandom), $urandom};
                step($urandom_range(0, 99) < 55, rd_data, $urandom_range(0, 99) < 45,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
